// File: rtl/two_port_fifo_ctrl.sv
// two_port_fifo_ctrl
//   FIFO controller that drives both ports of an external twoPortMem with a
//   one-cycle read latency. Pushes become memory writes. Reads are issued early
//   into a 2-entry output queue, so the pop side sees first-word-fall-through
//   data and the FIFO sustains one push plus one pop per cycle.
//
//   Handshakes: a transfer happens on a rising clk edge when valid and ready are
//   both high in the cycle before it. The producer holds inValid/inData until
//   it sees inReady. outValid/outData stay stable while outReady is low.
//   inReady and outValid depend only on registered state, never on the other
//   side's valid/ready. A full FIFO does not accept a push in a cycle that pops.
//
//   Occupancy: count = memCount + rdPend + outCount, where
//     memCount - words written to memory and not yet read-issued
//     rdPend   - a read was issued last cycle; readData lands in the queue now
//     outCount - words held in the output queue (0..2)
module two_port_fifo_ctrl #(
  parameter int addresses = 32,
  parameter int width = 8,
  localparam int addressWidth = $clog2(addresses)
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    inValid,
  output logic                    inReady,
  input  logic [width-1:0]        inData,
  output logic                    outValid,
  input  logic                    outReady,
  output logic [width-1:0]        outData,
  output logic [addressWidth:0]   count,
  output logic [addressWidth-1:0] writeAddress,
  output logic                    writeEnable,
  output logic [width-1:0]        writeData,
  output logic [addressWidth-1:0] readAddress,
  output logic                    readEnable,
  input  logic [width-1:0]        readData
);

  // Highest memory address; pointers wrap from here back to 0.
  localparam logic [addressWidth-1:0] lastAddress = addressWidth'(addresses - 1);
  localparam logic [addressWidth-1:0] addressOne  = addressWidth'(1);
  localparam logic [addressWidth:0]   capacity    = (addressWidth + 1)'(addresses);

  logic [addressWidth-1:0] wrPtr;
  logic [addressWidth-1:0] rdPtr;
  logic [addressWidth:0]   memCount;
  logic                    rdPend;
  logic [1:0]              outCount;
  logic [width-1:0]        queueHead;
  logic [width-1:0]        queueTail;

  logic                    push;
  logic                    pop;
  logic [2:0]              queueLoad;
  logic [1:0]              afterPop;
  logic [1:0]              outCountNext;
  logic [width-1:0]        headNext;
  logic [width-1:0]        tailNext;
  logic [addressWidth:0]   pushExt;
  logic [addressWidth:0]   popExt;
  logic [addressWidth:0]   readExt;

  // Push side: accept whenever fewer than 'addresses' words are held.
  always_comb begin
    inReady      = resetN & (count < capacity);
    push         = inValid & inReady;
    writeEnable  = push;
    writeAddress = wrPtr;
    writeData    = inData;
  end

  // Pop side and read issue: only read when the queue can absorb the word,
  // counting the read already in flight and the word leaving this cycle.
  always_comb begin
    outValid    = resetN & (outCount != 2'd0);
    outData     = queueHead;
    pop         = outValid & outReady;
    queueLoad   = {1'b0, outCount} + {2'b00, rdPend} - {2'b00, pop};
    readEnable  = resetN & (memCount != '0) & (queueLoad < 3'd2);
    readAddress = rdPtr;
  end

  // Output queue next state: pop shifts the tail forward, then returning read
  // data fills the first free slot behind whatever remains.
  always_comb begin
    headNext = queueHead;
    tailNext = queueTail;
    afterPop = outCount - {1'b0, pop};
    if (pop) begin
      headNext = queueTail;
    end
    if (rdPend) begin
      if (afterPop == 2'd0) begin
        headNext = readData;
      end else begin
        tailNext = readData;
      end
    end
    outCountNext = afterPop + {1'b0, rdPend};
  end

  // Zero-extended single-bit events for the occupancy counters.
  always_comb begin
    pushExt = {{addressWidth{1'b0}}, push};
    popExt  = {{addressWidth{1'b0}}, pop};
    readExt = {{addressWidth{1'b0}}, readEnable};
  end

  // State registers: pointers, occupancy counters, read-pending flag, queue.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      memCount  <= '0;
      rdPend    <= 1'b0;
      outCount  <= 2'd0;
      queueHead <= '0;
      queueTail <= '0;
      count     <= '0;
    end else begin
      if (push) begin
        wrPtr <= (wrPtr == lastAddress) ? '0 : wrPtr + addressOne;
      end
      if (readEnable) begin
        rdPtr <= (rdPtr == lastAddress) ? '0 : rdPtr + addressOne;
      end
      memCount  <= memCount + pushExt - readExt;
      rdPend    <= readEnable;
      outCount  <= outCountNext;
      queueHead <= headNext;
      queueTail <= tailNext;
      count     <= count + pushExt - popExt;
    end
  end

endmodule

// File: tb/tb_two_port_fifo_ctrl.sv
// Testbench for two_port_fifo_ctrl. Two instances (depth 32 and depth 24),
// each with its own memory model; 'sel' picks the active one.
module tb_two_port_fifo_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetN = 1'b0;
  logic       sel = 1'b0;
  logic       inValid = 1'b0;
  logic [7:0] inData = 8'h00;
  logic       outReady = 1'b0;

  logic       inReady0, inReady1, outValid0, outValid1;
  logic       writeEnable0, writeEnable1, readEnable0, readEnable1;
  logic [7:0] outData0, outData1, writeData0, writeData1, readData0, readData1;
  logic [5:0] count0, count1;
  logic [4:0] writeAddress0, writeAddress1, readAddress0, readAddress1;

  two_port_fifo_ctrl #(.addresses(32), .width(8)) dut0 (
    .clk(clk), .resetN(resetN),
    .inValid(inValid & ~sel), .inReady(inReady0), .inData(inData),
    .outValid(outValid0), .outReady(outReady & ~sel), .outData(outData0),
    .count(count0),
    .writeAddress(writeAddress0), .writeEnable(writeEnable0), .writeData(writeData0),
    .readAddress(readAddress0), .readEnable(readEnable0), .readData(readData0)
  );

  two_port_fifo_ctrl #(.addresses(24), .width(8)) dut1 (
    .clk(clk), .resetN(resetN),
    .inValid(inValid & sel), .inReady(inReady1), .inData(inData),
    .outValid(outValid1), .outReady(outReady & sel), .outData(outData1),
    .count(count1),
    .writeAddress(writeAddress1), .writeEnable(writeEnable1), .writeData(writeData1),
    .readAddress(readAddress1), .readEnable(readEnable1), .readData(readData1)
  );

  // twoPortMem models: write on the edge, read data one cycle after readEnable.
  logic [7:0] mem0 [32];
  logic [7:0] mem1 [32];
  always @(posedge clk) begin
    if (writeEnable0) mem0[writeAddress0] <= writeData0;
    if (readEnable0)  readData0 <= mem0[readAddress0];
    if (writeEnable1) mem1[writeAddress1] <= writeData1;
    if (readEnable1)  readData1 <= mem1[readAddress1];
  end

  // Views of the active instance.
  logic       dInReady, dOutValid, dWriteEnable, dReadEnable;
  logic [7:0] dOutData;
  logic [5:0] dCount;
  logic [4:0] dWriteAddress, dReadAddress;
  assign dInReady      = sel ? inReady1 : inReady0;
  assign dOutValid     = sel ? outValid1 : outValid0;
  assign dWriteEnable  = sel ? writeEnable1 : writeEnable0;
  assign dReadEnable   = sel ? readEnable1 : readEnable0;
  assign dOutData      = sel ? outData1 : outData0;
  assign dCount        = sel ? count1 : count0;
  assign dWriteAddress = sel ? writeAddress1 : writeAddress0;
  assign dReadAddress  = sel ? readAddress1 : readAddress0;

  int total = 0;
  int passed = 0;

  // ---------------- scoreboard ----------------
  // Reference: the FIFO is an ordered list of accepted words. Its size is the
  // expected count; inReady means "size below depth"; pops return the oldest.
  logic [7:0] exp_q[$];
  logic       holdValid = 1'b0;
  logic [7:0] holdData = 8'h00;

  always @(negedge clk) begin
    if (!resetN) begin
      exp_q.delete();
      holdValid = 1'b0;
    end else begin
      total++;
      if (dCount !== 6'(exp_q.size())) $display("FAIL mon_count: got %0d expected %0d", dCount, exp_q.size());
      else passed++;
      total++;
      if (dInReady !== (exp_q.size() < (sel ? 24 : 32))) $display("FAIL mon_inReady: got %0b expected %0b", dInReady, exp_q.size() < (sel ? 24 : 32));
      else passed++;
      if (holdValid) begin
        total++;
        if (dOutValid !== 1'b1 || dOutData !== holdData) $display("FAIL mon_stable: got valid %0b data %h expected valid 1 data %h", dOutValid, dOutData, holdData);
        else passed++;
      end
      if (dOutValid && outReady) begin
        total++;
        if (exp_q.size() == 0) $display("FAIL mon_pop_empty: got data %h expected no word", dOutData);
        else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (dOutData !== e) $display("FAIL mon_order: got %h expected %h", dOutData, e);
          else passed++;
        end
      end
      if (inValid && dInReady) exp_q.push_back(inData);
      holdValid = dOutValid && !outReady;
      holdData  = dOutData;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    tick();
    resetN = 1'b0;
    inValid = 1'b0;
    outReady = 1'b0;
    tick();
    tick();
    resetN = 1'b1;
  endtask

  task automatic push_word(input logic [7:0] d);
    bit ok = 0;
    inValid = 1'b1;
    inData = d;
    for (int c = 0; c < 64 && !ok; c++) begin
      @(negedge clk);
      if (dInReady) ok = 1;
      tick();
    end
    inValid = 1'b0;
    if (!ok) begin
      total++;
      $display("FAIL push_timeout: got no inReady expected accept of %h", d);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    sel = 1'b0;
    tick();
    resetN = 1'b0;
    inValid = 1'b1;
    outReady = 1'b0;
    tick();
    @(negedge clk);
    total++;
    if (dInReady !== 1'b0 || dOutValid !== 1'b0 || dWriteEnable !== 1'b0 || dReadEnable !== 1'b0)
      $display("FAIL reset_hold: got inReady %0b outValid %0b we %0b re %0b expected all 0", dInReady, dOutValid, dWriteEnable, dReadEnable);
    else passed++;
    tick();
    resetN = 1'b1;
    inValid = 1'b0;
    @(negedge clk);
    total++;
    if (dOutValid !== 1'b0 || dInReady !== 1'b1 || dCount !== 6'd0 || dWriteEnable !== 1'b0 || dReadEnable !== 1'b0)
      $display("FAIL reset_release: got outValid %0b inReady %0b count %0d we %0b re %0b expected 0 1 0 0 0", dOutValid, dInReady, dCount, dWriteEnable, dReadEnable);
    else passed++;
  endtask

  task automatic test_single_word();
    sel = 1'b0;
    apply_reset();
    inValid = 1'b1;
    inData = 8'hA5;
    outReady = 1'b1;
    @(negedge clk);
    total++;
    if (dWriteEnable !== 1'b1 || dWriteAddress !== 5'd0) $display("FAIL single_write: got we %0b addr %0d expected 1 0", dWriteEnable, dWriteAddress);
    else passed++;
    tick();
    inValid = 1'b0;
    @(negedge clk);
    total++;
    if (dReadEnable !== 1'b1 || dOutValid !== 1'b0) $display("FAIL single_read: got re %0b outValid %0b expected 1 0", dReadEnable, dOutValid);
    else passed++;
    tick();
    @(negedge clk);
    total++;
    if (dOutValid !== 1'b0) $display("FAIL single_early: got outValid %0b expected 0", dOutValid);
    else passed++;
    tick();
    @(negedge clk);
    total++;
    if (dOutValid !== 1'b1 || dOutData !== 8'hA5) $display("FAIL single_data: got valid %0b data %h expected 1 a5", dOutValid, dOutData);
    else passed++;
    tick();
    @(negedge clk);
    total++;
    if (dCount !== 6'd0 || dOutValid !== 1'b0) $display("FAIL single_empty: got count %0d valid %0b expected 0 0", dCount, dOutValid);
    else passed++;
    outReady = 1'b0;
  endtask

  task automatic test_fill_drain();
    sel = 1'b0;
    apply_reset();
    outReady = 1'b0;
    for (int i = 0; i < 32; i++) push_word(8'(i));
    repeat (3) tick();
    @(negedge clk);
    total++;
    if (dCount !== 6'd32 || dInReady !== 1'b0) $display("FAIL fill_full: got count %0d inReady %0b expected 32 0", dCount, dInReady);
    else passed++;
    tick();
    inValid = 1'b1;
    inData = 8'hEE;
    @(negedge clk);
    total++;
    if (dWriteEnable !== 1'b0) $display("FAIL fill_holdoff: got we %0b expected 0", dWriteEnable);
    else passed++;
    tick();
    tick();
    inValid = 1'b0;
    outReady = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      total++;
      if (dOutValid !== 1'b1 || dOutData !== 8'(i)) $display("FAIL drain_word: got valid %0b data %h expected 1 %h", dOutValid, dOutData, 8'(i));
      else passed++;
      tick();
    end
    @(negedge clk);
    total++;
    if (dCount !== 6'd0 || dOutValid !== 1'b0) $display("FAIL drain_empty: got count %0d valid %0b expected 0 0", dCount, dOutValid);
    else passed++;
    tick();
    outReady = 1'b0;
  endtask

  task automatic test_streaming();
    int pushed = 0, popped = 0, firstPop = -1, lastPop = -1;
    sel = 1'b0;
    apply_reset();
    outReady = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      inValid = (pushed < 100);
      inData = 8'($urandom);
      @(negedge clk);
      total++;
      if (dCount > 6'd3) $display("FAIL stream_count: got %0d expected <= 3", dCount);
      else passed++;
      if (inValid && dInReady) pushed++;
      if (dOutValid && outReady) begin
        if (firstPop < 0) firstPop = cyc;
        lastPop = cyc;
        popped++;
      end
      tick();
      if (popped == 100) break;
    end
    inValid = 1'b0;
    outReady = 1'b0;
    total++;
    if (popped != 100 || lastPop - firstPop != 99) $display("FAIL stream_rate: got %0d pops over %0d cycles expected 100 over 100", popped, lastPop - firstPop + 1);
    else passed++;
  endtask

  task automatic test_wrap();
    int pushed = 0, popped = 0, nW = 0, nR = 0;
    sel = 1'b1;
    apply_reset();
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (pushed < 250) begin
        inValid = ($urandom_range(0, 3) != 0);
        outReady = ($urandom_range(0, 3) == 0);
      end else begin
        inValid = (pushed < 500) && ($urandom_range(0, 1) != 0);
        outReady = ($urandom_range(0, 3) != 0);
      end
      inData = 8'($urandom);
      @(negedge clk);
      if (dWriteEnable) begin
        total++;
        if (dWriteAddress !== 5'(nW % 24)) $display("FAIL wrap_waddr: got %0d expected %0d", dWriteAddress, nW % 24);
        else passed++;
        nW++;
      end
      if (dReadEnable) begin
        total++;
        if (dReadAddress !== 5'(nR % 24)) $display("FAIL wrap_raddr: got %0d expected %0d", dReadAddress, nR % 24);
        else passed++;
        nR++;
      end
      if (inValid && dInReady) pushed++;
      if (dOutValid && outReady) popped++;
      tick();
      if (popped == 500) break;
    end
    inValid = 1'b0;
    outReady = 1'b0;
    total++;
    if (popped != 500 || nW != 500 || nR != 500) $display("FAIL wrap_total: got pops %0d writes %0d reads %0d expected 500 each", popped, nW, nR);
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    sel = 1'b0;
    apply_reset();
    outReady = 1'b0;
    for (int i = 0; i < 10; i++) push_word(8'(8'h40 + i));
    repeat (3) tick();
    inValid = 1'b1;
    inData = 8'h77;
    outReady = 1'b1;
    @(negedge clk);
    total++;
    if (dReadEnable !== 1'b1 || dCount !== 6'd10) $display("FAIL mid_setup: got re %0b count %0d expected 1 10", dReadEnable, dCount);
    else passed++;
    tick();
    inValid = 1'b0;
    outReady = 1'b0;
    resetN = 1'b0;
    @(negedge clk);
    total++;
    if (dCount !== 6'd10 || dOutValid !== 1'b0) $display("FAIL mid_inreset: got count %0d valid %0b expected 10 0", dCount, dOutValid);
    else passed++;
    tick();
    resetN = 1'b1;
    outReady = 1'b1;
    @(negedge clk);
    total++;
    if (dCount !== 6'd0 || dOutValid !== 1'b0) $display("FAIL mid_cleared: got count %0d valid %0b expected 0 0", dCount, dOutValid);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      total++;
      if (dOutValid !== 1'b0) $display("FAIL mid_stale: got valid %0b data %h expected 0", dOutValid, dOutData);
      else passed++;
    end
    tick();
    push_word(8'h3C);
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (dOutValid) found = 1;
      else tick();
    end
    total++;
    if (!found || dOutData !== 8'h3C) $display("FAIL mid_first: got valid %0b data %h expected 1 3c", found, dOutData);
    else passed++;
    tick();
    outReady = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_word();
    test_fill_drain();
    test_streaming();
    test_wrap();
    test_reset_mid();
    repeat (2) tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
